// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback unit: register index names,
// default data width, queue entry layout and the forwarding match rules.
package regfile_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] REG_ZERO   = 3'd0;
  localparam logic [2:0] REG_CARRY  = 3'd1;
  localparam logic [2:0] REG_A      = 3'd2;
  localparam logic [2:0] REG_B      = 3'd3;
  localparam logic [2:0] REG_C      = 3'd4;
  localparam logic [2:0] REG_D      = 3'd5;
  localparam logic [2:0] REG_SP     = 3'd6;
  localparam logic [2:0] REG_BRANCH = 3'd7;

  typedef struct packed {
    logic [2:0]        idx;
    logic [DATA_W-1:0] val;
    logic              carry;
  } wb_entry_t;

  // A carry-setting entry owns the carry register regardless of its own index.
  function automatic logic entry_carry_read(input logic e_carry, input logic [2:0] r);
    return e_carry && (r == REG_CARRY);
  endfunction

  function automatic logic entry_hit(input logic [2:0] e_idx, input logic e_carry,
                                     input logic [2:0] r);
    return (r != REG_ZERO) && ((e_idx == r) || entry_carry_read(e_carry, r));
  endfunction

endpackage

// File: rtl/wb_queue.sv
// Two-entry FIFO of pending register writes; exposes the head (oldest) and the
// entry behind it so the top can forward from both.
module wb_queue #(
  parameter int DATA_W = 8
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [2:0]        i_idx,
  input  logic [DATA_W-1:0] i_val,
  input  logic              i_carry,
  output logic [1:0]        o_count,
  output logic [2:0]        o_head_idx,
  output logic [DATA_W-1:0] o_head_val,
  output logic              o_head_carry,
  output logic [2:0]        o_next_idx,
  output logic [DATA_W-1:0] o_next_val,
  output logic              o_next_carry
);

  logic [2:0]        r_idx   [2];
  logic [DATA_W-1:0] r_val   [2];
  logic              r_carry [2];
  logic              r_head;
  logic [1:0]        r_count;
  logic              w_tail;

  // With two slots the tail is the head slot when empty or full, the other one otherwise.
  assign w_tail = r_head ^ r_count[0];

  // Storage, head pointer and occupancy update.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 2; i++) begin
        r_idx[i]   <= 3'd0;
        r_val[i]   <= {DATA_W{1'b0}};
        r_carry[i] <= 1'b0;
      end
      r_head  <= 1'b0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_head  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) begin
        r_idx[w_tail]   <= i_idx;
        r_val[w_tail]   <= i_val;
        r_carry[w_tail] <= i_carry;
      end
      if (i_pop) begin
        r_head <= ~r_head;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count      = r_count;
  assign o_head_idx   = r_idx[r_head];
  assign o_head_val   = r_val[r_head];
  assign o_head_carry = r_carry[r_head];
  assign o_next_idx   = r_idx[~r_head];
  assign o_next_val   = r_val[~r_head];
  assign o_next_carry = r_carry[~r_head];

endmodule

// File: rtl/regfile_writeback.sv
// Writeback unit: queues register writes, issues the oldest one to the register
// file when it is not busy, and forwards pending values to the operand readers.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_reg,
  input  logic [DATA_W-1:0] in_val,
  input  logic              in_carry,
  input  logic              rf_hold,
  input  logic              flush,
  output logic              write_ctrl,
  output logic [2:0]        write_reg,
  output logic [DATA_W-1:0] write_val,
  output logic              carry_out,
  input  logic [1:0]        read_reg1,
  input  logic [2:0]        read_reg2,
  output logic              fwd_hit1,
  output logic [DATA_W-1:0] fwd_val1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_val2,
  output logic [1:0]        pending
);

  logic [1:0]        w_count;
  logic [2:0]        w_head_idx;
  logic [DATA_W-1:0] w_head_val;
  logic              w_head_carry;
  logic [2:0]        w_next_idx;
  logic [DATA_W-1:0] w_next_val;
  logic              w_next_carry;
  logic              w_has_head;
  logic              w_full;
  logic              w_issue;
  logic              w_push;

  assign w_has_head = (w_count != 2'd0);
  assign w_full     = (w_count == 2'(DEPTH));
  assign w_issue    = w_has_head && !rf_hold;
  assign w_push     = in_valid && in_ready && !flush;

  // A full queue still accepts when its head leaves in the same cycle.
  assign in_ready   = !w_full || w_issue;

  wb_queue #(.DATA_W(DATA_W)) u_queue (
    .i_clock      (clock),
    .i_reset_n    (reset_n),
    .i_push       (w_push),
    .i_pop        (w_issue),
    .i_flush      (flush),
    .i_idx        (in_reg),
    .i_val        (in_val),
    .i_carry      (in_carry),
    .o_count      (w_count),
    .o_head_idx   (w_head_idx),
    .o_head_val   (w_head_val),
    .o_head_carry (w_head_carry),
    .o_next_idx   (w_next_idx),
    .o_next_val   (w_next_val),
    .o_next_carry (w_next_carry)
  );

  assign write_ctrl = w_issue;
  assign write_reg  = w_has_head ? w_head_idx   : 3'd0;
  assign write_val  = w_has_head ? w_head_val   : {DATA_W{1'b0}};
  assign carry_out  = w_has_head ? w_head_carry : 1'b0;
  assign pending    = w_count;

  // Head is checked first so the newer entry overrides it when both match.
  function automatic logic [DATA_W:0] fwd_lookup(
    input logic [2:0]        r,
    input logic [1:0]        cnt,
    input logic [2:0]        h_idx,
    input logic [DATA_W-1:0] h_val,
    input logic              h_carry,
    input logic [2:0]        n_idx,
    input logic [DATA_W-1:0] n_val,
    input logic              n_carry
  );
    logic              hit;
    logic [DATA_W-1:0] v;
    hit = 1'b0;
    v   = {DATA_W{1'b0}};
    if ((cnt != 2'd0) && entry_hit(h_idx, h_carry, r)) begin
      hit = 1'b1;
      v   = entry_carry_read(h_carry, r) ? {{(DATA_W-1){1'b0}}, 1'b1} : h_val;
    end else begin
      hit = hit;
    end
    if ((cnt == 2'd2) && entry_hit(n_idx, n_carry, r)) begin
      hit = 1'b1;
      v   = entry_carry_read(n_carry, r) ? {{(DATA_W-1){1'b0}}, 1'b1} : n_val;
    end else begin
      hit = hit;
    end
    return {hit, v};
  endfunction

  assign {fwd_hit1, fwd_val1} = fwd_lookup({1'b0, read_reg1}, w_count, w_head_idx, w_head_val,
                                           w_head_carry, w_next_idx, w_next_val, w_next_carry);
  assign {fwd_hit2, fwd_val2} = fwd_lookup(read_reg2, w_count, w_head_idx, w_head_val,
                                           w_head_carry, w_next_idx, w_next_val, w_next_carry);

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: a queue model tracks accepted writes,
// outputs are compared against it every falling edge, plus directed scenario checks.
module tb_regfile_writeback;
  import regfile_pkg::*;

  logic       clock;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_reg;
  logic [7:0] in_val;
  logic       in_carry;
  logic       rf_hold;
  logic       flush;
  logic       write_ctrl;
  logic [2:0] write_reg;
  logic [7:0] write_val;
  logic       carry_out;
  logic [1:0] read_reg1;
  logic [2:0] read_reg2;
  logic       fwd_hit1;
  logic [7:0] fwd_val1;
  logic       fwd_hit2;
  logic [7:0] fwd_val2;
  logic [1:0] pending;

  int n_checks = 0;
  int n_errors = 0;
  wb_entry_t sb_q[$];

  regfile_writeback #(.DATA_W(8), .DEPTH(2)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_reg     (in_reg),
    .in_val     (in_val),
    .in_carry   (in_carry),
    .rf_hold    (rf_hold),
    .flush      (flush),
    .write_ctrl (write_ctrl),
    .write_reg  (write_reg),
    .write_val  (write_val),
    .carry_out  (carry_out),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .fwd_hit1   (fwd_hit1),
    .fwd_val1   (fwd_val1),
    .fwd_hit2   (fwd_hit2),
    .fwd_val2   (fwd_val2),
    .pending    (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] r, input logic [7:0] d, input logic c);
    in_valid = v;
    in_reg   = r;
    in_val   = d;
    in_carry = c;
  endtask

  // Forwarding reference: walk the model queue oldest to newest, last match wins.
  function automatic logic [8:0] fwd_exp(input logic [2:0] r);
    logic       hit;
    logic [7:0] v;
    hit = 1'b0;
    v   = 8'h00;
    foreach (sb_q[i]) begin
      if (r != 3'd0) begin
        if (sb_q[i].carry && r == 3'd1) begin
          hit = 1'b1;
          v   = 8'h01;
        end else if (sb_q[i].idx == r) begin
          hit = 1'b1;
          v   = sb_q[i].val;
        end
      end
    end
    return {hit, v};
  endfunction

  // Scoreboard update: pop on an issued write, push on an accepted offer, clear on flush/reset.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sb_q.delete();
    end else begin
      logic pop_now;
      logic acc_now;
      pop_now = (sb_q.size() != 0) && !rf_hold;
      acc_now = in_valid && ((sb_q.size() < 2) || pop_now) && !flush;
      if (flush) begin
        sb_q.delete();
      end else begin
        if (pop_now) void'(sb_q.pop_front());
        if (acc_now) sb_q.push_back('{idx: in_reg, val: in_val, carry: in_carry});
      end
    end
  end

  // Compare every observable output against the scoreboard each falling edge.
  always @(negedge clock) begin
    logic [8:0] f1;
    logic [8:0] f2;
    logic       has;
    has = (sb_q.size() != 0);
    f1  = fwd_exp({1'b0, read_reg1});
    f2  = fwd_exp(read_reg2);
    check_eq("mon_pending", pending, sb_q.size());
    check_eq("mon_in_ready", in_ready, (sb_q.size() < 2) || (has && !rf_hold));
    check_eq("mon_write_ctrl", write_ctrl, has && !rf_hold);
    check_eq("mon_write_reg", write_reg, has ? sb_q[0].idx : 3'd0);
    check_eq("mon_write_val", write_val, has ? sb_q[0].val : 8'h00);
    check_eq("mon_carry_out", carry_out, has ? sb_q[0].carry : 1'b0);
    check_eq("mon_fwd1", {fwd_hit1, fwd_val1}, f1);
    check_eq("mon_fwd2", {fwd_hit2, fwd_val2}, f2);
  end

  initial begin
    reset_n   = 1'b0;
    rf_hold   = 1'b0;
    flush     = 1'b0;
    read_reg1 = 2'd0;
    read_reg2 = 3'd0;
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    #2;
    check_eq("rst_write_ctrl", write_ctrl, 1'b0);
    check_eq("rst_pending", pending, 2'd0);
    check_eq("rst_fwd_hit2", fwd_hit2, 1'b0);
    #10 reset_n = 1'b1;
    tick();

    // Single write with an idle queue issues in the following cycle.
    drive(1'b1, 3'd2, 8'h5A, 1'b0);
    tick();
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    @(negedge clock);
    check_eq("lat_write_ctrl", write_ctrl, 1'b1);
    check_eq("lat_write_reg", write_reg, 3'd2);
    check_eq("lat_write_val", write_val, 8'h5A);
    tick();
    @(negedge clock);
    check_eq("lat_pending_after", pending, 2'd0);

    // Fill under hold, third offer refused, then drain in order.
    tick();
    rf_hold = 1'b1;
    drive(1'b1, 3'd3, 8'h31, 1'b0);
    tick();
    drive(1'b1, 3'd5, 8'h52, 1'b0);
    tick();
    drive(1'b1, 3'd6, 8'h63, 1'b0);
    @(negedge clock);
    check_eq("full_pending", pending, 2'd2);
    check_eq("full_in_ready", in_ready, 1'b0);
    tick();
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    rf_hold = 1'b0;
    @(negedge clock);
    check_eq("drain0_reg", write_reg, 3'd3);
    check_eq("drain0_val", write_val, 8'h31);
    tick();
    @(negedge clock);
    check_eq("drain1_reg", write_reg, 3'd5);
    check_eq("drain1_val", write_val, 8'h52);
    tick();

    // Two writes to the same register: the newer one forwards.
    rf_hold   = 1'b1;
    read_reg2 = 3'd4;
    drive(1'b1, 3'd4, 8'h11, 1'b0);
    tick();
    drive(1'b1, 3'd4, 8'h22, 1'b0);
    tick();
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    @(negedge clock);
    check_eq("fwd_newest_hit2", fwd_hit2, 1'b1);
    check_eq("fwd_newest_val2", fwd_val2, 8'h22);
    tick();

    // Flush while full and issuing: current write still shown, push discarded.
    rf_hold = 1'b0;
    flush   = 1'b1;
    drive(1'b1, 3'd7, 8'hEE, 1'b0);
    @(negedge clock);
    check_eq("flush_write_ctrl", write_ctrl, 1'b1);
    check_eq("flush_write_val", write_val, 8'h11);
    tick();
    flush = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    @(negedge clock);
    check_eq("flush_pending", pending, 2'd0);
    check_eq("flush_no_write", write_ctrl, 1'b0);
    tick();

    // Carry entry forwards 1 on register 1; index 0 never forwards.
    rf_hold   = 1'b1;
    read_reg1 = 2'd1;
    read_reg2 = 3'd0;
    drive(1'b1, 3'd3, 8'h80, 1'b1);
    tick();
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    @(negedge clock);
    check_eq("carry_fwd_hit1", fwd_hit1, 1'b1);
    check_eq("carry_fwd_val1", fwd_val1, 8'h01);
    check_eq("carry_fwd_hit2", fwd_hit2, 1'b0);
    tick();
    read_reg2 = 3'd3;
    @(negedge clock);
    check_eq("carry_fwd_val2", fwd_val2, 8'h80);
    tick();
    rf_hold = 1'b0;
    tick();

    // Random traffic exercising simultaneous push/pop, holds and flushes.
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 3) == 0));
      rf_hold   = 1'($urandom_range(0, 3) == 0);
      flush     = 1'($urandom_range(0, 15) == 0);
      read_reg1 = 2'($urandom_range(0, 3));
      read_reg2 = 3'($urandom_range(0, 7));
      tick();
    end
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    flush   = 1'b0;
    rf_hold = 1'b0;
    tick();
    tick();
    tick();

    // Asynchronous reset mid-cycle with one write pending.
    rf_hold = 1'b1;
    drive(1'b1, 3'd2, 8'h44, 1'b0);
    tick();
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    rf_hold = 1'b0;
    #1;
    check_eq("prereset_write_ctrl", write_ctrl, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check_eq("async_rst_write_ctrl", write_ctrl, 1'b0);
    check_eq("async_rst_pending", pending, 2'd0);
    check_eq("async_rst_write_val", write_val, 8'h00);
    @(negedge clock);
    #2 reset_n = 1'b1;
    tick();
    drive(1'b1, 3'd5, 8'h77, 1'b0);
    tick();
    drive(1'b0, 3'd0, 8'h00, 1'b0);
    @(negedge clock);
    check_eq("post_rst_write_ctrl", write_ctrl, 1'b1);
    check_eq("post_rst_write_reg", write_reg, 3'd5);
    check_eq("post_rst_write_val", write_val, 8'h77);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 Parameter DATA_W, default 8, register data width.
REQ-002 Parameter DEPTH, default 2, pending-write queue entries; only 2 is supported.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  producer offers a writeback.
REQ-006 in_ready  out  1  unit accepts the offer this cycle.
REQ-007 in_reg  in  3  destination register index.
REQ-008 in_val  in  DATA_W  destination value.
REQ-009 in_carry  in  1  writeback also sets register 1 to 1.
REQ-010 rf_hold  in  1  register file busy with a swap; no write issued.
REQ-011 flush  in  1  discard all pending writes.
REQ-012 write_ctrl  out  1  register-file write enable.
REQ-013 write_reg  out  3  register-file write index.
REQ-014 write_val  out  DATA_W  register-file write data.
REQ-015 carry_out  out  1  register-file carry-write flag.
REQ-016 read_reg1  in  2  operand-1 index being read this cycle.
REQ-017 read_reg2  in  3  operand-2 index being read this cycle.
REQ-018 fwd_hit1 / fwd_val1  out  1 / DATA_W  pending value for read_reg1.
REQ-019 fwd_hit2 / fwd_val2  out  1 / DATA_W  pending value for read_reg2.
REQ-020 pending  out  2  count of queued writes, 0..2.

Function
REQ-021 Queue is FIFO of {reg, val, carry}; head = oldest entry.
REQ-022 in_ready = (pending < 2) or (pending == 2 and head issues this cycle) -- combinational.
REQ-023 Push on rising edge when in_valid and in_ready and not flush.
REQ-024 Issue: write_ctrl = (pending != 0) and not rf_hold; write_reg/write_val/carry_out = head fields, combinational from head register.
REQ-025 Head pops on the rising edge ending any cycle with write_ctrl = 1; one pop per cycle max.
REQ-026 Latency: entry accepted at edge N with empty queue and rf_hold = 0 has write_ctrl = 1 for the whole cycle after edge N.
REQ-027 Simultaneous push and pop: pending unchanged, order preserved.
REQ-028 Full (pending = 2), rf_hold = 1: in_ready = 0, outputs stable, no loss.
REQ-029 Empty: write_ctrl = 0; write_reg, write_val, carry_out = 0.
REQ-030 flush: pending -> 0 next edge, same-cycle push discarded, write_ctrl still follows REQ-024 for the current cycle.
REQ-031 Forwarding compares read index to every queued entry; newest matching entry wins.
REQ-032 Entry matches index r if entry.reg == r and r != 0 and not (entry.carry and r == 1).
REQ-033 Entry with carry = 1 also matches r == 1, with forwarded value 1 (zero-extended).
REQ-034 Index 0 never forwards; fwd_hit = 0, fwd_val = 0 when no match.
REQ-035 Entries with in_reg = 0 are queued and issued normally (register file ignores them).

Reset
REQ-036 reset_n low: queue empty, pending = 0, write_ctrl = 0, all write_* and fwd_* outputs 0, immediately and asynchronously.
REQ-037 Reset mid-queue discards entries; first write after release obeys REQ-026.

Structure
REQ-038 Shared package regfile_pkg: REG_ZERO..REG_BRANCH index constants (0..7), DATA_W, entry struct type.
REQ-039 One sub-module wb_queue (2-entry FIFO, head/tail storage, count); forwarding and issue logic in top.

Verification
REQ-040 Push {reg 2, 0x5A, carry 0}, idle queue -> next cycle write_ctrl = 1, write_reg = 2, write_val = 0x5A, then pending = 0.
REQ-041 rf_hold = 1, push 3 entries back-to-back -> pending = 2, third in_valid sees in_ready = 0; release hold -> writes issue in order over 2 cycles.
REQ-042 Queue {reg 4, 0x11}, {reg 4, 0x22} with hold, read_reg2 = 4 -> fwd_hit2 = 1, fwd_val2 = 0x22.
REQ-043 Queue {reg 3, 0x80, carry 1}, read_reg1 = 1, read_reg2 = 0 -> fwd_val1 = 0x01, fwd_hit1 = 1, fwd_hit2 = 0.
REQ-044 pending = 2, assert flush with in_valid = 1 -> pending = 0 next cycle, no write of the flushed-cycle push.
REQ-045 reset_n low mid-cycle with pending = 1 -> write_ctrl drops to 0 without a clock edge.
